// File: rtl/room_pkg.sv
// Shared definitions for the room adventure move path: direction indices,
// encoder FSM states and a one-hot test used by the press arbiter.
package room_pkg;

  localparam int DIR_N    = 0;
  localparam int DIR_S    = 1;
  localparam int DIR_E    = 2;
  localparam int DIR_W    = 3;
  localparam int NUM_DIRS = 4;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_EMIT,
    ENC_HOLD
  } enc_state_t;

  function automatic logic is_one_hot(input logic [NUM_DIRS-1:0] v);
    return (v != '0) && ((v & (v - NUM_DIRS'(1))) == '0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one raw button; level/press change SYNC_STAGES+DEBOUNCE_CYCLES-1
// cycles after the first sampling edge; no backpressure (press is a lone one-cycle pulse).
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic quiet
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  // Quiet means released end to end: nothing high anywhere in the synchronizer either.
  assign quiet  = (sync_q == '0) && !level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      press  <= 1'b0;
      if (synced == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        level <= synced;
        press <= synced;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/room_move_encoder.sv
// Turns four bouncy buttons into one-hot n/s/e/w move pulses, flags chords, counts moves.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 from first sampling edge to move; no backpressure.
module room_move_encoder
  import room_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLDOFF_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       chord_err,
  output logic [7:0] move_count
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  logic [1:0]             rst_pipe;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] warm_q;
  logic [NUM_DIRS-1:0]    raw;
  logic [NUM_DIRS-1:0]    level;
  logic [NUM_DIRS-1:0]    press;
  logic [NUM_DIRS-1:0]    quiet;

  enc_state_t             state_q;
  logic [NUM_DIRS-1:0]    dir_q;
  logic [NUM_DIRS-1:0]    move_q;
  logic                   chord_q;
  logic [HW-1:0]          holdoff_q;
  logic [7:0]             move_count_q;
  logic                   all_quiet;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  assign raw[DIR_N] = btn_n;
  assign raw[DIR_S] = btn_s;
  assign raw[DIR_E] = btn_e;
  assign raw[DIR_W] = btn_w;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (raw[i]),
      .level (level[i]),
      .press (press[i]),
      .quiet (quiet[i])
    );
  end

  // Until the synchronizers have refilled after reset their zeros say nothing about
  // the buttons, so HOLD must not trust them; this is what blocks held-through-reset moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q <= '0;
    end else begin
      warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign all_quiet = warm_q[SYNC_STAGES-1] && (quiet == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ENC_HOLD;
      dir_q        <= '0;
      move_q       <= '0;
      chord_q      <= 1'b0;
      holdoff_q    <= '0;
      move_count_q <= '0;
    end else begin
      move_q  <= '0;
      chord_q <= 1'b0;
      unique case (state_q)
        ENC_IDLE: begin
          if (press != '0) begin
            if (is_one_hot(press) && ((level & ~press) == '0)) begin
              dir_q   <= press;
              state_q <= ENC_EMIT;
            end else begin
              chord_q <= 1'b1;
            end
          end
        end
        ENC_EMIT: begin
          move_q       <= dir_q;
          move_count_q <= move_count_q + 8'd1;
          holdoff_q    <= HW'(HOLDOFF_CYCLES);
          state_q      <= ENC_HOLD;
        end
        ENC_HOLD: begin
          if (holdoff_q != '0) begin
            holdoff_q <= holdoff_q - HW'(1);
          end else if (all_quiet) begin
            state_q <= ENC_IDLE;
          end
        end
        default: state_q <= ENC_HOLD;
      endcase
    end
  end

  assign n          = move_q[DIR_N];
  assign s          = move_q[DIR_S];
  assign e          = move_q[DIR_E];
  assign w          = move_q[DIR_W];
  assign chord_err  = chord_q;
  assign move_count = move_count_q;

endmodule

// File: tb/tb_room_move_encoder.sv
// Scoreboard bench for room_move_encoder with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3.
module tb_room_move_encoder;

  localparam logic [4:0] EV_N     = 5'b00001;
  localparam logic [4:0] EV_S     = 5'b00010;
  localparam logic [4:0] EV_E     = 5'b00100;
  localparam logic [4:0] EV_CHORD = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_n = 1'b0;
  logic       btn_s = 1'b0;
  logic       btn_e = 1'b0;
  logic       btn_w = 1'b0;
  logic       n;
  logic       s;
  logic       e;
  logic       w;
  logic       chord_err;
  logic [7:0] move_count;

  int         checks = 0;
  int         failures = 0;
  int         move_pulses = 0;
  logic [4:0] exp_q[$];
  logic [7:0] exp_count = 8'd0;
  logic [4:0] mon_obs;
  logic [4:0] mon_exp;

  always #5 clk = ~clk;

  room_move_encoder #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .HOLDOFF_CYCLES  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .btn_s      (btn_s),
    .btn_e      (btn_e),
    .btn_w      (btn_w),
    .n          (n),
    .s          (s),
    .e          (e),
    .w          (w),
    .chord_err  (chord_err),
    .move_count (move_count)
  );

  // Scoreboard: every observed output pulse must match the oldest expected event.
  always @(negedge clk) begin
    mon_obs = {chord_err, w, e, s, n};
    if (mon_obs != 5'b0) begin
      if (mon_obs[3:0] != 4'b0) move_pulses++;
      checks++;
      if ($countones(mon_obs) != 1) begin
        failures++;
        $display("FAIL exclusive outputs got=%b required=one-hot", mon_obs);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got=%b required=none", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          failures++;
          $display("FAIL pulse_kind got=%b required=%b", mon_obs, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int d, input logic v);
    case (d)
      0:       btn_n = v;
      1:       btn_s = v;
      2:       btn_e = v;
      default: btn_w = v;
    endcase
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(4);
    exp_count = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    checks++;
    if ({chord_err, w, e, s, n} !== 5'b0 || move_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_hold outs=%b count=%0d required=0/0", {chord_err, w, e, s, n}, move_count);
    end
    reset = 1'b1;
    tick(6);
    exp_count = 8'd0;
    checks++;
    if ({chord_err, w, e, s, n} !== 5'b0 || move_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_release outs=%b count=%0d required=0/0", {chord_err, w, e, s, n}, move_count);
    end
  endtask

  task automatic test_single_move();
    logic exp_n;
    btn_n = 1'b1;
    exp_q.push_back(EV_N);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      exp_n = (k == 7);
      checks++;
      if (n !== exp_n || {chord_err, w, e, s} !== 4'b0) begin
        failures++;
        $display("FAIL latency edge=%0d n=%b others=%b required n=%b others=0", k, n, {chord_err, w, e, s}, exp_n);
      end
      if (k == 7) begin
        exp_count = exp_count + 8'd1;
        checks++;
        if (move_count !== exp_count) begin
          failures++;
          $display("FAIL count_step got=%0d required=%0d", move_count, exp_count);
        end
      end
    end
    btn_n = 1'b0;
    tick(15);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_missing pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_bounce();
    exp_q.push_back(EV_S);
    for (int k = 0; k < 20; k++) begin
      btn_s = ((k / 2) % 2) == 0;
      tick(1);
      checks++;
      if (s !== 1'b0) begin
        failures++;
        $display("FAIL bounce_pulse cycle=%0d s=%b required=0", k, s);
      end
    end
    btn_s = 1'b1;
    tick(12);
    btn_s = 1'b0;
    tick(15);
    exp_count = exp_count + 8'd1;
    checks++;
    if (exp_q.size() != 0 || move_count !== exp_count) begin
      failures++;
      $display("FAIL bounce_result pending=%0d count=%0d required 0/%0d", exp_q.size(), move_count, exp_count);
    end
  endtask

  task automatic test_chord();
    btn_n = 1'b1;
    btn_e = 1'b1;
    exp_q.push_back(EV_CHORD);
    tick(12);
    btn_n = 1'b0;
    btn_e = 1'b0;
    tick(15);
    checks++;
    if (exp_q.size() != 0 || move_count !== exp_count) begin
      failures++;
      $display("FAIL chord_result pending=%0d count=%0d required 0/%0d", exp_q.size(), move_count, exp_count);
    end
  endtask

  task automatic test_overlap();
    btn_e = 1'b1;
    exp_q.push_back(EV_E);
    tick(12);
    btn_w = 1'b1;
    tick(12);
    btn_e = 1'b0;
    btn_w = 1'b0;
    tick(15);
    exp_q.push_back(EV_S);
    btn_s = 1'b1;
    tick(12);
    btn_s = 1'b0;
    tick(15);
    exp_count = exp_count + 8'd2;
    checks++;
    if (exp_q.size() != 0 || move_count !== exp_count) begin
      failures++;
      $display("FAIL overlap_result pending=%0d count=%0d required 0/%0d", exp_q.size(), move_count, exp_count);
    end
  endtask

  task automatic test_held_through_reset();
    btn_w = 1'b1;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    exp_count = 8'd0;
    tick(20);
    btn_w = 1'b0;
    tick(15);
    checks++;
    if (move_count !== 8'd0) begin
      failures++;
      $display("FAIL held_reset_count got=%0d required=0", move_count);
    end
    exp_q.push_back(EV_N);
    btn_n = 1'b1;
    tick(12);
    btn_n = 1'b0;
    tick(15);
    exp_count = exp_count + 8'd1;
    checks++;
    if (exp_q.size() != 0 || move_count !== exp_count) begin
      failures++;
      $display("FAIL held_reset_result pending=%0d count=%0d required 0/%0d", exp_q.size(), move_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    int         start_pulses;
    logic [4:0] ev;
    apply_reset();
    start_pulses = move_pulses;
    for (int i = 0; i < 256; i++) begin
      ev = 5'b00001;
      ev = ev << (i % 4);
      exp_q.push_back(ev);
      set_btn(i % 4, 1'b1);
      tick(12);
      set_btn(i % 4, 1'b0);
      tick(14);
      exp_count = exp_count + 8'd1;
    end
    checks++;
    if (move_count !== exp_count) begin
      failures++;
      $display("FAIL wrap_count got=%0d required=%0d", move_count, exp_count);
    end
    checks++;
    if (move_pulses - start_pulses != 256) begin
      failures++;
      $display("FAIL wrap_pulses got=%0d required=256", move_pulses - start_pulses);
    end
  endtask

  task automatic test_reset_in_emit();
    exp_q.push_back(EV_S);
    btn_s = 1'b1;
    tick(12);
    btn_s = 1'b0;
    tick(15);
    exp_count = exp_count + 8'd1;
    checks++;
    if (move_count !== exp_count) begin
      failures++;
      $display("FAIL pre_emit_count got=%0d required=%0d", move_count, exp_count);
    end
    btn_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    exp_count = 8'd0;
    checks++;
    if ({chord_err, w, e, s, n} !== 5'b0 || move_count !== 8'd0) begin
      failures++;
      $display("FAIL emit_reset outs=%b count=%0d required=0/0", {chord_err, w, e, s, n}, move_count);
    end
    tick(3);
    reset = 1'b1;
    tick(20);
    btn_n = 1'b0;
    tick(15);
    checks++;
    if (exp_q.size() != 0 || move_count !== 8'd0) begin
      failures++;
      $display("FAIL emit_reset_after pending=%0d count=%0d required 0/0", exp_q.size(), move_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_bounce();
    test_chord();
    test_overlap();
    test_held_through_reset();
    test_wrap();
    test_reset_in_emit();
    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
